updown_counter_n: RTL

- Parametrised, registered up/down counter; the sequential successor to the 4-bit combinational increment/decrement datapath.
- Adds:
  - programmable width and modulus
  - variable step
  - parallel load
  - wrap or saturate mode
  - registered carry/borrow pulse and a sticky overflow flag
- Sits in the arithmetic library. Used as an address/sequence counter by datapath blocks.

---
 rtl/updown_counter_n_pkg.sv | 21 ++
 rtl/updown_counter_n_if.sv | 24 ++
 rtl/updown_counter_n_addsub.sv | 31 +++
 rtl/updown_counter_n.sv | 111 +++++++++++
 4 files changed

// File: rtl/updown_counter_n_pkg.sv
// Shared constants and helpers for the up/down counter family.
package updown_pkg;

   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DN    = 1'b1;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Terminal count: top of range when counting up, zero when counting down.
   function automatic logic term_cnt(input logic dir, input logic [31:0] q,
                                     input logic [31:0] max_v);
      logic hit;
      if (dir == DIR_DN) begin
         hit = (q == 32'd0);
      end else begin
         hit = (q == max_v);
      end
      return hit;
   endfunction

endpackage

// File: rtl/updown_counter_n_if.sv
// Control/status bundle between a counter client (master) and the counter (slave).
interface updown_counter_n_if #(parameter int WIDTH = 4);
   logic             en_i;
   logic             dir_i;
   logic [WIDTH-1:0] step_i;
   logic             sat_i;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;
   logic             clr_ovf_i;
   logic [WIDTH-1:0] q_o;
   logic             cout_o;
   logic             tc_o;
   logic             ovf_o;

   modport master (
      output en_i, dir_i, step_i, sat_i, load_i, load_val_i, clr_ovf_i,
      input  q_o, cout_o, tc_o, ovf_o
   );

   modport slave (
      input  en_i, dir_i, step_i, sat_i, load_i, load_val_i, clr_ovf_i,
      output q_o, cout_o, tc_o, ovf_o
   );
endinterface

// File: rtl/updown_counter_n_addsub.sv
// WIDTH-bit ripple adder/subtractor; co_o is carry on add, borrow on subtract.
module addsub_n #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] y_o,
   output logic             co_o
);

   // Ripple xor/and chain; subtraction is a + ~b + 1 with inverted final carry.
   always_comb begin
      logic [WIDTH:0]   c_v;
      logic [WIDTH-1:0] bx_v;
      bx_v   = b_i ^ {WIDTH{sub_i}};
      c_v    = '0;
      c_v[0] = sub_i;
      y_o    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         y_o[i]   = a_i[i] ^ bx_v[i] ^ c_v[i];
         c_v[i+1] = (a_i[i] & bx_v[i]) | (c_v[i] & (a_i[i] ^ bx_v[i]));
      end
      if (sub_i) begin
         co_o = ~c_v[WIDTH];
      end else begin
         co_o = c_v[WIDTH];
      end
   end

endmodule

// File: rtl/updown_counter_n.sv
// Registered up/down counter with programmable modulus, step, load,
// wrap/saturate mode, carry/borrow pulse and sticky overflow.
module updown_counter_n
   import updown_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   updown_counter_n_if.slave  cnt_if
);

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_VAL) + (WIDTH+1)'(1);
   localparam logic             TC_RST  = (RESET_VAL == MAX_VAL);

   logic [WIDTH-1:0] q_q, q_d;
   logic             cout_q, cout_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] as_y;
   logic             as_co;
   logic [WIDTH:0]   ext_s;
   logic             up_over;
   logic [WIDTH-1:0] wrap_up;
   logic [WIDTH-1:0] wrap_dn;
   logic [WIDTH-1:0] load_clamp;

   addsub_n #(.WIDTH(WIDTH)) u_addsub (
      .a_i   (q_q),
      .b_i   (cnt_if.step_i),
      .sub_i (cnt_if.dir_i),
      .y_o   (as_y),
      .co_o  (as_co)
   );

   // Sum (add) or two's-complement difference (subtract) at WIDTH+1 bits,
   // plus the modulus-corrected wrap results for both directions.
   always_comb begin
      ext_s      = {as_co, as_y};
      up_over    = (ext_s > MAX_EXT);
      wrap_up    = WIDTH'(ext_s - MOD_EXT);
      wrap_dn    = WIDTH'(ext_s + MOD_EXT);
      if (cnt_if.load_val_i > MAX_Q) begin
         load_clamp = MAX_Q;
      end else begin
         load_clamp = cnt_if.load_val_i;
      end
   end

   // Next-state decode: load beats count; overflow picks wrap or saturate.
   always_comb begin
      q_d    = q_q;
      cout_d = 1'b0;
      if (cnt_if.load_i) begin
         q_d = load_clamp;
      end else if (cnt_if.en_i) begin
         if (cnt_if.dir_i == DIR_UP) begin
            if (up_over) begin
               cout_d = 1'b1;
               q_d    = (cnt_if.sat_i == MODE_SAT) ? MAX_Q : wrap_up;
            end else begin
               q_d = as_y;
            end
         end else begin
            if (as_co) begin
               cout_d = 1'b1;
               q_d    = (cnt_if.sat_i == MODE_SAT) ? '0 : wrap_dn;
            end else begin
               q_d = as_y;
            end
         end
      end else begin
         q_d = q_q;
      end
      tc_d = term_cnt(cnt_if.dir_i, 32'(q_d), 32'(MAX_Q));
      if (cout_d) begin
         ovf_d = 1'b1;
      end else if (cnt_if.clr_ovf_i) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q    <= RST_Q;
         cout_q <= 1'b0;
         tc_q   <= TC_RST;
         ovf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         cout_q <= cout_d;
         tc_q   <= tc_d;
         ovf_q  <= ovf_d;
      end
   end

   assign cnt_if.q_o    = q_q;
   assign cnt_if.cout_o = cout_q;
   assign cnt_if.tc_o   = tc_q;
   assign cnt_if.ovf_o  = ovf_q;

endmodule
